// File: rtl/activation_pipe.sv
// Two-stage streaming activation stage (bypass / ReLU / leaky / clip).
// Valid/ready on both sides, global enable stall, delivered-beat counter.
module activation_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        clip_max,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LENGTH*DATA_WIDTH-1:0] In,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH*DATA_WIDTH-1:0] Out,
    output logic [CNT_WIDTH-1:0]         beat_count
);

    logic                         s1_valid;
    logic [LENGTH*DATA_WIDTH-1:0] s1_data;
    logic [1:0]                   s1_mode;
    logic [DATA_WIDTH-1:0]        s1_clip;
    logic                         s2_valid;
    logic [LENGTH*DATA_WIDTH-1:0] s2_data;
    logic                         s1_advance;
    logic                         accept;
    logic                         move;
    logic                         deliver;
    logic [LENGTH*DATA_WIDTH-1:0] result;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [DATA_WIDTH-1:0] c;

    assign s1_advance = ~s2_valid | out_ready;
    assign in_ready   = en & (~s1_valid | s1_advance);
    assign accept     = in_valid & in_ready;
    assign move       = en & s1_valid & s1_advance;
    assign deliver    = en & s2_valid & out_ready;
    assign out_valid  = s2_valid;
    assign Out        = s2_data;

    // Per-lane activation of the beat waiting in stage 1.
    always_comb begin
        result = '0;
        x      = '0;
        y      = '0;
        c      = s1_clip[DATA_WIDTH-1] ? '0 : $signed(s1_clip);
        for (int i = 0; i < LENGTH; i++) begin
            x = $signed(s1_data[i*DATA_WIDTH +: DATA_WIDTH]);
            unique case (s1_mode)
                2'b00: y = x;
                2'b01: y = x[DATA_WIDTH-1] ? '0 : x;
                2'b10: y = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
                2'b11: y = x[DATA_WIDTH-1] ? '0 : ((x > c) ? c : x);
                default: y = x;
            endcase
            result[i*DATA_WIDTH +: DATA_WIDTH] = y;
        end
    end

    // Stage 1: captures the raw beat with its mode and clamp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'b00;
            s1_clip  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= In;
            s1_mode  <= mode;
            s1_clip  <= clip_max;
        end else if (move) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: registers the activated beat, held until handed off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (move) begin
            s2_valid <= 1'b1;
            s2_data  <= result;
        end else if (deliver) begin
            s2_valid <= 1'b0;
        end
    end

    // Counts beats handed downstream; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (deliver) begin
            beat_count <= beat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed self-checking bench for activation_pipe.
// Small lane count and a 4-bit counter so wrap-around is reachable.
module tb_activation_pipe;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] clip_max;
    logic          in_valid;
    logic          in_ready;
    logic [L*DW-1:0] in_bus;
    logic          out_valid;
    logic          out_ready;
    logic [L*DW-1:0] out_bus;
    logic [CW-1:0] beat_count;

    int checks = 0;
    int errors = 0;

    activation_pipe #(
        .DATA_WIDTH(DW),
        .LENGTH(L),
        .LEAK_SHIFT(3),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .clip_max(clip_max),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .In(in_bus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out(out_bus),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [L*DW-1:0] lanes(
        input int a0, input int a1, input int a2,
        input int a3, input int a4
    );
        logic [L*DW-1:0] v;
        v = '0;
        v[0*DW +: DW] = a0[DW-1:0];
        v[1*DW +: DW] = a1[DW-1:0];
        v[2*DW +: DW] = a2[DW-1:0];
        v[3*DW +: DW] = a3[DW-1:0];
        v[4*DW +: DW] = a4[DW-1:0];
        return v;
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; reset = 1; en = 1; mode = 0; clip_max = 0;
        in_valid = 0; in_bus = '0; out_ready = 1;

        #23;
        chk("rst_ov", 128'(out_valid), 128'(0));
        chk("rst_out", 128'(out_bus), 128'(0));
        chk("rst_cnt", 128'(beat_count), 128'(0));
        reset = 0;
        tick();
        chk("idle_rdy", 128'(in_ready), 128'(1));
        chk("idle_ov", 128'(out_valid), 128'(0));

        // ReLU
        mode = 2'b01;
        in_bus = lanes(0, 32767, -32768, -1, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("relu_lat", 128'(out_valid), 128'(0));
        tick();
        chk("relu_ov", 128'(out_valid), 128'(1));
        chk("relu_out", 128'(out_bus), 128'(lanes(0, 32767, 0, 0, 0)));
        chk("relu_cnt0", 128'(beat_count), 128'(0));
        tick();
        chk("relu_done", 128'(out_valid), 128'(0));
        chk("relu_cnt1", 128'(beat_count), 128'(1));

        // Leaky ReLU, shift 3
        mode = 2'b10;
        in_bus = lanes(-8, -1, -32768, 100, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        chk("leak_out", 128'(out_bus), 128'(lanes(-1, -1, -4096, 100, 0)));
        tick();
        chk("leak_cnt", 128'(beat_count), 128'(2));

        // Clipped ReLU, then negative clamp back-to-back
        mode = 2'b11;
        clip_max = 16'd6;
        in_bus = lanes(-5, 3, 6, 7, 32767);
        in_valid = 1;
        tick();
        clip_max = 16'hFFFC;
        in_bus = lanes(9, 0, 0, 0, 0);
        tick();
        in_valid = 0;
        chk("clip_ov", 128'(out_valid), 128'(1));
        chk("clip_out", 128'(out_bus), 128'(lanes(0, 3, 6, 6, 6)));
        tick();
        chk("clipneg_out", 128'(out_bus), 128'(lanes(0, 0, 0, 0, 0)));
        chk("clipneg_ov", 128'(out_valid), 128'(1));
        chk("clip_cnt3", 128'(beat_count), 128'(3));
        tick();
        chk("clip_idle", 128'(out_valid), 128'(0));
        chk("clip_cnt4", 128'(beat_count), 128'(4));

        // Backpressure with alternating modes
        out_ready = 0;
        mode = 2'b00;
        in_bus = lanes(-3, 1, 0, 0, 0);
        in_valid = 1;
        tick();
        mode = 2'b01;
        in_bus = lanes(-3, 11, 0, 0, 0);
        tick();
        mode = 2'b00;
        in_bus = lanes(-7, 2, 0, 0, 0);
        chk("bp_rdy", 128'(in_ready), 128'(0));
        chk("bp_out", 128'(out_bus), 128'(lanes(-3, 1, 0, 0, 0)));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_ov", 128'(out_valid), 128'(1));
            chk("bp_hold_out", 128'(out_bus), 128'(lanes(-3, 1, 0, 0, 0)));
            chk("bp_hold_rdy", 128'(in_ready), 128'(0));
        end
        chk("bp_cnt", 128'(beat_count), 128'(4));
        out_ready = 1;
        tick();
        chk("bp_b1", 128'(out_bus), 128'(lanes(0, 11, 0, 0, 0)));
        chk("bp_cnt5", 128'(beat_count), 128'(5));
        mode = 2'b01;
        in_bus = lanes(5, -9, 0, 0, 0);
        tick();
        in_valid = 0;
        chk("bp_b2", 128'(out_bus), 128'(lanes(-7, 2, 0, 0, 0)));
        tick();
        chk("bp_b3", 128'(out_bus), 128'(lanes(5, 0, 0, 0, 0)));
        chk("bp_b3_ov", 128'(out_valid), 128'(1));
        tick();
        chk("bp_idle", 128'(out_valid), 128'(0));
        chk("bp_cnt8", 128'(beat_count), 128'(8));

        // Enable stall with full pipeline
        mode = 2'b10;
        in_bus = lanes(-16, 0, 0, 0, 0);
        in_valid = 1;
        tick();
        mode = 2'b11;
        clip_max = 16'd100;
        in_bus = lanes(200, 50, 0, 0, 0);
        tick();
        en = 0;
        mode = 2'b01;
        in_bus = lanes(-1, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_rdy", 128'(in_ready), 128'(0));
            chk("en_ov", 128'(out_valid), 128'(1));
            chk("en_out", 128'(out_bus), 128'(lanes(-2, 0, 0, 0, 0)));
            chk("en_cnt", 128'(beat_count), 128'(8));
        end
        en = 1;
        tick();
        in_valid = 0;
        chk("en_c1", 128'(out_bus), 128'(lanes(100, 50, 0, 0, 0)));
        chk("en_cnt9", 128'(beat_count), 128'(9));
        tick();
        chk("en_c2", 128'(out_bus), 128'(lanes(0, 5, 0, 0, 0)));
        chk("en_cnt10", 128'(beat_count), 128'(10));
        tick();
        chk("en_idle", 128'(out_valid), 128'(0));
        chk("en_cnt11", 128'(beat_count), 128'(11));

        // Asynchronous reset with two beats in flight
        out_ready = 0;
        mode = 2'b00;
        in_bus = lanes(42, 0, 0, 0, 0);
        in_valid = 1;
        tick();
        in_bus = lanes(43, 0, 0, 0, 0);
        tick();
        in_valid = 0;
        chk("mr_pre_ov", 128'(out_valid), 128'(1));
        #3 reset = 1;
        #1;
        chk("mr_ov", 128'(out_valid), 128'(0));
        chk("mr_out", 128'(out_bus), 128'(0));
        chk("mr_cnt", 128'(beat_count), 128'(0));
        #2 reset = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_stale", 128'(out_valid), 128'(0));
        end

        // Full-rate stream of 17 beats; counter wraps at 16
        mode = 2'b00;
        in_bus = lanes(1, 0, 0, 0, 0);
        in_valid = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i >= 1)
                chk("tp_ov", 128'(out_valid), 128'(1));
        end
        in_valid = 0;
        tick();
        tick();
        chk("wrap_ov", 128'(out_valid), 128'(0));
        chk("wrap_cnt", 128'(beat_count), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
